// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end feeding the decode pipe register.
//
// Holds the fetch PC, issues in-order word requests to instruction memory and
// buffers the returned words with their PCs in a DEPTH-entry circular queue.
// A branch redirect flushes all buffered and in-flight fetches and restarts
// fetching at the target. Responses belonging to flushed requests are counted
// in a drop counter and discarded as they return.
//
// Ports:
//   clk, reset         clock and synchronous active-low reset
//   imem_req/addr      word fetch request (addr is 4-byte aligned)
//   imem_gnt           memory accepts the request this cycle
//   imem_rvalid/rdata  in-order response from memory
//   redirect/_pc       branch taken: flush and refetch at redirect_pc
//   out_valid/instr/pc head instruction offered to decode
//   out_ready          decode consumes the head
//   occupancy          reserved slots (filled plus awaiting response)
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [63:0]                imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [63:0]                redirect_pc,
    output logic                       out_valid,
    output logic [31:0]                out_instr,
    output logic [63:0]                out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    // Back-to-back redirects can stack up to 2*DEPTH stale responses.
    localparam int unsigned DropW = $clog2(2 * DEPTH + 1);

    logic [63:0]      fetch_pc_q;
    logic [63:0]      slot_pc_q    [DEPTH];
    logic [31:0]      slot_instr_q [DEPTH];
    logic [DEPTH-1:0] slot_filled_q;
    logic [PtrW-1:0]  head_q;
    logic [PtrW-1:0]  fill_q;
    logic [PtrW-1:0]  tail_q;
    logic [CntW-1:0]  reserved_q;
    logic [DropW-1:0] drop_q;

    logic [CntW-1:0]  filled_cnt;
    logic [CntW-1:0]  unfilled_cnt;
    logic             head_valid;
    logic             pop;
    logic             grant;
    logic             resp_keep;
    logic             resp_drop;
    logic             unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    always_comb begin
        filled_cnt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            filled_cnt = filled_cnt + CntW'(slot_filled_q[i]);
        end
    end

    // Reserved slots still waiting for their response.
    assign unfilled_cnt = reserved_q - filled_cnt;

    assign head_valid = slot_filled_q[head_q];
    assign pop        = reset & ~redirect & head_valid & out_ready;

    // A pop frees the head slot in time for a same-cycle grant into it.
    assign imem_req  = reset & ~redirect & ((reserved_q < CntW'(DEPTH)) | pop);
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req & imem_gnt;

    assign resp_drop = imem_rvalid & (drop_q != '0);
    // A response with nothing outstanding is ignored.
    assign resp_keep = imem_rvalid & (drop_q == '0) & (unfilled_cnt != '0);

    assign out_valid = reset & head_valid;
    assign out_instr = out_valid ? slot_instr_q[head_q] : 32'h0;
    assign out_pc    = out_valid ? slot_pc_q[head_q] : 64'h0;
    assign occupancy = reset ? reserved_q : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            slot_filled_q <= '0;
            head_q        <= '0;
            fill_q        <= '0;
            tail_q        <= '0;
            reserved_q    <= '0;
            drop_q        <= '0;
        end else if (redirect) begin
            fetch_pc_q    <= {redirect_pc[63:2], 2'b00};
            slot_filled_q <= '0;
            head_q        <= '0;
            fill_q        <= '0;
            tail_q        <= '0;
            reserved_q    <= '0;
            // Every in-flight response becomes stale, less one arriving now.
            drop_q        <= drop_q + DropW'(unfilled_cnt) - DropW'(resp_keep | resp_drop);
        end else begin
            if (resp_keep) begin
                slot_instr_q[fill_q]  <= imem_rdata;
                slot_filled_q[fill_q] <= 1'b1;
                fill_q                <= fill_q + PtrW'(1);
            end
            if (resp_drop) begin
                drop_q <= drop_q - DropW'(1);
            end
            if (pop) begin
                slot_filled_q[head_q] <= 1'b0;
                head_q                <= head_q + PtrW'(1);
            end
            if (grant) begin
                slot_pc_q[tail_q]     <= fetch_pc_q;
                slot_filled_q[tail_q] <= 1'b0;
                tail_q                <= tail_q + PtrW'(1);
                fetch_pc_q            <= fetch_pc_q + 64'd4;
            end
            reserved_q <= reserved_q + CntW'(grant) - CntW'(pop);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(imem_rvalid && drop_q == '0 && unfilled_cnt == '0))
                else $error("fetch_queue: response with no outstanding request");
            assert (reserved_q <= CntW'(DEPTH))
                else $error("fetch_queue: reserved count exceeds DEPTH");
            assert (({1'b0, drop_q} + (DropW + 1)'(reserved_q)) <= (DropW + 1)'(2 * DEPTH))
                else $error("fetch_queue: drop plus reserved exceeds 2*DEPTH");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run compared cycle by cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [63:0]   imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [63:0]   redirect_pc;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [63:0]   out_pc;
    logic          out_ready;
    logic [CW-1:0] occupancy;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (64'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_ready   (out_ready),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus staged by the tests, applied at the next falling edge.
    logic        s_reset       = 1'b0;
    logic        s_redirect    = 1'b0;
    logic        s_out_ready   = 1'b0;
    logic [63:0] s_redirect_pc = 64'h0;
    int          g_mode        = 0;  // grant: 0 always, 1 random, 2 never
    int          r_mode        = 0;  // respond: 0 always, 1 random, 2 never

    // Memory: addresses granted and not yet answered, in order.
    logic [63:0] mem_q[$];

    // Reference model: fetch pc, pcs of reserved slots in order, how many of
    // them (a prefix) have data, and how many stale responses are still due.
    logic [63:0] m_pc;
    logic [63:0] m_pcs[$];
    int          m_nfill;
    int          m_stale;

    // Observed outputs and model expectations for the current cycle.
    logic          o_req, o_valid, o_grant;
    logic [63:0]   o_addr, o_pc;
    logic [31:0]   o_instr;
    logic [CW-1:0] o_occ;
    logic          e_req, e_valid, e_pop;
    logic [63:0]   e_addr, e_pc;
    logic [31:0]   e_instr;
    int            e_occ;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: drive inputs, sample outputs, advance model and memory.
    task automatic cycle();
        @(negedge clk);
        reset       = s_reset;
        redirect    = s_redirect;
        redirect_pc = s_redirect_pc;
        out_ready   = s_out_ready;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (s_reset && mem_q.size() > 0 &&
            (r_mode == 0 || (r_mode == 1 && $urandom_range(0, 2) != 0))) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0]);
        end
        imem_gnt = (g_mode == 0 || (g_mode == 1 && $urandom_range(0, 1) == 1)) &&
                   ((mem_q.size() - (imem_rvalid ? 1 : 0)) < DEPTH);
        #1;
        o_req   = imem_req;
        o_addr  = imem_addr;
        o_valid = out_valid;
        o_pc    = out_pc;
        o_instr = out_instr;
        o_occ   = occupancy;
        o_grant = imem_req & imem_gnt;

        e_valid = s_reset && m_nfill > 0;
        e_pc    = e_valid ? m_pcs[0] : 64'h0;
        e_instr = e_valid ? mem_word(m_pcs[0]) : 32'h0;
        e_occ   = s_reset ? m_pcs.size() : 0;
        e_pop   = e_valid && s_out_ready && !s_redirect;
        e_req   = s_reset && !s_redirect && (m_pcs.size() < DEPTH || e_pop);
        e_addr  = m_pc;

        if (!s_reset) begin
            m_pc    = 64'h0;
            m_pcs.delete();
            m_nfill = 0;
            m_stale = 0;
            mem_q.delete();
        end else begin
            if (imem_rvalid) begin
                if (m_stale > 0) m_stale--;
                else if (m_nfill < m_pcs.size()) m_nfill++;
            end
            if (s_redirect) begin
                m_stale += m_pcs.size() - m_nfill;
                m_pcs.delete();
                m_nfill = 0;
                m_pc    = {s_redirect_pc[63:2], 2'b00};
            end else begin
                if (e_pop) begin
                    void'(m_pcs.pop_front());
                    m_nfill--;
                end
                if (e_req && imem_gnt) begin
                    m_pcs.push_back(m_pc);
                    m_pc = m_pc + 64'd4;
                end
            end
            if (imem_rvalid) void'(mem_q.pop_front());
            if (o_grant) mem_q.push_back(o_addr);
        end
    endtask

    task automatic do_reset();
        s_reset    = 1'b0;
        s_redirect = 1'b0;
        repeat (2) cycle();
        s_reset = 1'b1;
    endtask

    task automatic test_reset();
        s_reset = 1'b0; s_redirect = 1'b0; s_out_ready = 1'b1; g_mode = 0; r_mode = 0;
        repeat (3) cycle();
        n_checks++;
        if (o_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", o_req); end
        n_checks++;
        if (o_valid !== 1'b0 || o_pc !== 64'h0 || o_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out got=%0b/%h/%h exp=0/0/0", o_valid, o_pc, o_instr);
        end
        n_checks++;
        if (o_occ !== '0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", o_occ); end
        s_reset = 1'b1;
        cycle();
        n_checks++;
        if (o_valid !== 1'b0 || o_occ !== '0) begin
            n_fail++;
            $display("FAIL post_reset_state got valid=%0b occ=%0d exp 0/0", o_valid, o_occ);
        end
        n_checks++;
        if (o_req !== 1'b1 || o_addr !== 64'h0) begin
            n_fail++;
            $display("FAIL post_reset_req got=%0b/%h exp=1/0", o_req, o_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        s_out_ready = 1'b1; g_mode = 0; r_mode = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            n_checks++;
            if (o_req !== 1'b1 || o_addr !== 64'(4 * k)) begin
                n_fail++;
                $display("FAIL stream_req[%0d] got=%0b/%h exp=1/%h", k, o_req, o_addr, 4 * k);
            end
            n_checks++;
            if (k < 2) begin
                if (o_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_latency[%0d] got valid=%0b exp=0", k, o_valid);
                end
            end else if (o_valid !== 1'b1 || o_pc !== 64'(4 * (k - 2)) ||
                         o_instr !== mem_word(64'(4 * (k - 2)))) begin
                n_fail++;
                $display("FAIL stream_out[%0d] got=%0b/%h/%h exp=1/%h/%h", k, o_valid, o_pc,
                         o_instr, 4 * (k - 2), mem_word(64'(4 * (k - 2))));
            end
        end
    endtask

    task automatic test_backpressure();
        int ngrant = 0;
        do_reset();
        s_out_ready = 1'b0; g_mode = 0; r_mode = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (o_grant) begin
                n_checks++;
                if (o_addr !== 64'(4 * ngrant)) begin
                    n_fail++;
                    $display("FAIL bp_grant_addr got=%h exp=%h", o_addr, 4 * ngrant);
                end
                ngrant++;
            end
        end
        n_checks++;
        if (ngrant != 4) begin n_fail++; $display("FAIL bp_grants got=%0d exp=4", ngrant); end
        n_checks++;
        if (o_req !== 1'b0 || o_occ !== CW'(4)) begin
            n_fail++;
            $display("FAIL bp_full got req=%0b occ=%0d exp 0/4", o_req, o_occ);
        end
        s_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_checks++;
            if (o_valid !== 1'b1 || o_pc !== 64'(4 * k)) begin
                n_fail++;
                $display("FAIL bp_pop[%0d] got=%0b/%h exp=1/%h", k, o_valid, o_pc, 4 * k);
            end
            if (k == 0) begin
                n_checks++;
                if (o_grant !== 1'b1 || o_addr !== 64'h10) begin
                    n_fail++;
                    $display("FAIL bp_grant_on_pop got=%0b/%h exp=1/10", o_grant, o_addr);
                end
            end
        end
    endtask

    // Wait (bounded) for the next n outputs and compare them to pcs base, base+4, ...
    task automatic expect_outputs(input string name, input logic [63:0] base, input int n);
        int got = 0;
        for (int k = 0; k < 16 && got < n; k++) begin
            cycle();
            if (o_valid) begin
                n_checks++;
                if (o_pc !== base + 64'(4 * got) || o_instr !== mem_word(base + 64'(4 * got))) begin
                    n_fail++;
                    $display("FAIL %s_out[%0d] got=%h/%h exp=%h/%h", name, got, o_pc, o_instr,
                             base + 64'(4 * got), mem_word(base + 64'(4 * got)));
                end
                got++;
            end
        end
        n_checks++;
        if (got != n) begin n_fail++; $display("FAIL %s_timeout got=%0d exp=%0d", name, got, n); end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        s_out_ready = 1'b1; g_mode = 0; r_mode = 2;
        repeat (2) cycle();
        g_mode = 2;
        s_redirect = 1'b1; s_redirect_pc = 64'h100;
        cycle();
        n_checks++;
        if (o_req !== 1'b0) begin n_fail++; $display("FAIL rdi_req got=%0b exp=0", o_req); end
        s_redirect = 1'b0; g_mode = 0; r_mode = 0;
        cycle();
        n_checks++;
        if (o_req !== 1'b1 || o_addr !== 64'h100 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rdi_restart got=%0b/%h/%0b exp=1/100/0", o_req, o_addr, o_valid);
        end
        expect_outputs("rdi", 64'h100, 2);
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        s_out_ready = 1'b1; g_mode = 0; r_mode = 0;
        repeat (5) cycle();
        s_redirect = 1'b1; s_redirect_pc = 64'h100;
        cycle();
        n_checks++;
        if (o_req !== 1'b0) begin n_fail++; $display("FAIL rdc_req got=%0b exp=0", o_req); end
        s_redirect = 1'b0;
        cycle();
        n_checks++;
        if (o_req !== 1'b1 || o_addr !== 64'h100 || o_valid !== 1'b0 || o_occ !== '0) begin
            n_fail++;
            $display("FAIL rdc_next got=%0b/%h/%0b/%0d exp=1/100/0/0", o_req, o_addr, o_valid,
                     o_occ);
        end
        expect_outputs("rdc", 64'h100, 2);
    endtask

    task automatic test_align_wrap();
        do_reset();
        s_out_ready = 1'b1; g_mode = 2; r_mode = 0;
        s_redirect = 1'b1; s_redirect_pc = 64'h203;
        cycle();
        s_redirect = 1'b0;
        cycle();
        n_checks++;
        if (o_addr !== 64'h200) begin n_fail++; $display("FAIL align got=%h exp=200", o_addr); end
        s_redirect = 1'b1; s_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        s_redirect = 1'b0; g_mode = 0;
        cycle();
        n_checks++;
        if (o_grant !== 1'b1 || o_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_top got=%0b/%h exp=1/fffffffffffffffc", o_grant, o_addr);
        end
        cycle();
        n_checks++;
        if (o_addr !== 64'h0) begin n_fail++; $display("FAIL wrap_zero got=%h exp=0", o_addr); end
        expect_outputs("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 2);
    endtask

    task automatic test_reset_midop();
        do_reset();
        s_out_ready = 1'b0; g_mode = 0; r_mode = 0;
        repeat (3) cycle();
        r_mode = 2;
        repeat (3) cycle();
        n_checks++;
        if (o_occ !== CW'(4)) begin n_fail++; $display("FAIL midrst_full got=%0d exp=4", o_occ); end
        s_reset = 1'b0;
        cycle();
        s_reset = 1'b1; s_out_ready = 1'b1; r_mode = 0;
        cycle();
        n_checks++;
        if (o_valid !== 1'b0 || o_occ !== '0 || o_addr !== 64'h0 || o_req !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_after got=%0b/%0d/%h/%0b exp=0/0/0/1", o_valid, o_occ, o_addr,
                     o_req);
        end
        cycle();
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_lat got=%0b exp=0", o_valid); end
        cycle();
        n_checks++;
        if (o_valid !== 1'b1 || o_pc !== 64'h0) begin
            n_fail++;
            $display("FAIL midrst_first got=%0b/%h exp=1/0", o_valid, o_pc);
        end
    endtask

    task automatic test_random();
        do_reset();
        g_mode = 1; r_mode = 1;
        for (int k = 0; k < 3000 && n_fail < 40; k++) begin
            s_out_ready   = ($urandom_range(0, 3) != 0);
            s_redirect    = ($urandom_range(0, 15) == 0);
            s_redirect_pc = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) begin
                s_redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            end
            cycle();
            n_checks++;
            if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr) begin
                n_fail++;
                $display("FAIL rand_out[%0d] got=%0b/%h/%h exp=%0b/%h/%h", k, o_valid, o_pc,
                         o_instr, e_valid, e_pc, e_instr);
            end
            n_checks++;
            if (o_req !== e_req || o_addr !== e_addr) begin
                n_fail++;
                $display("FAIL rand_req[%0d] got=%0b/%h exp=%0b/%h", k, o_req, o_addr, e_req,
                         e_addr);
            end
            n_checks++;
            if (int'(o_occ) != e_occ) begin
                n_fail++;
                $display("FAIL rand_occ[%0d] got=%0d exp=%0d", k, o_occ, e_occ);
            end
        end
        s_redirect = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        out_ready   = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        m_pc        = 64'h0;
        m_nfill     = 0;
        m_stale     = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_align_wrap();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
